// File: rtl/ext_bus_ctrl.sv
// Bus interface unit: turns 32-bit core requests into multiplexed 16-bit
// external bus cycles, with a cached upper address half to skip le_hi phases.
module ext_bus_ctrl #(
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic        req_word,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wstrb,
   output logic        ack,
   output logic [31:0] rdata,
   output logic [15:0] bus_out,
   input  logic [15:0] bus_in,
   output logic        bus_oe,
   output logic        le_lo,
   output logic        le_hi,
   output logic        bus_dir,
   output logic        OEb,
   output logic        WEb_lo,
   output logic        WEb_hi
);

   localparam int unsigned AW = 32;
   localparam int unsigned HW = 16;
   localparam int unsigned CW = 4;

   typedef enum logic [2:0] {IDLE, AH, AL, RD, TURN, WP, WH, DONE} state_t;

   state_t          state, state_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic [AW-1:0]   cur, cur_n;
   logic [HW-1:0]   cache, cache_n;
   logic            hi_valid, hi_valid_n;
   logic            half, half_n;
   logic            r_we, we_n;
   logic            r_word, word_n;
   logic [31:0]     r_wdata, wdata_n;
   logic [3:0]      r_wstrb, wstrb_n;
   logic [31:0]     rdata_n;
   logic [HW-1:0]   bus_out_n;
   logic            req_ready_n, ack_n, le_lo_n, le_hi_n, bus_dir_n;
   logic            oeb_n, web_lo_n, web_hi_n;
   logic            second;
   logic [AW-1:0]   haddr;
   logic [HW-1:0]   wp_data;
   logic [1:0]      wp_strb;

   // Byte address to halfword address; bit 0 is dropped by the shift.
   assign haddr = req_addr >> 1;

   // Next-state, datapath and next-output logic.
   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      cur_n       = cur;
      cache_n     = cache;
      hi_valid_n  = hi_valid;
      half_n      = half;
      we_n        = r_we;
      word_n      = r_word;
      wdata_n     = r_wdata;
      wstrb_n     = r_wstrb;
      rdata_n     = rdata;
      bus_out_n   = bus_out;
      req_ready_n = 1'b0;
      ack_n       = 1'b0;
      le_lo_n     = 1'b0;
      le_hi_n     = 1'b0;
      bus_dir_n   = 1'b0;
      oeb_n       = 1'b1;
      web_lo_n    = 1'b1;
      web_hi_n    = 1'b1;
      wp_data     = '0;
      wp_strb     = '0;
      second      = !half && ((!r_we && r_word) || (r_we && (r_wstrb[3:2] != 2'b00)));

      case (state)
         IDLE: begin
            if (req_valid) begin
               we_n    = req_we;
               word_n  = req_word;
               wdata_n = req_wdata;
               wstrb_n = req_wstrb;
               rdata_n = '0;
               cur_n   = haddr;
               half_n  = 1'b0;
               if (req_we && (req_wstrb == 4'b0000)) begin
                  state_n = DONE;
               end else begin
                  if (req_we && (req_wstrb[1:0] == 2'b00)) begin
                     cur_n  = haddr + AW'(1);
                     half_n = 1'b1;
                  end
                  state_n = (hi_valid && (cache == cur_n[31:16])) ? AL : AH;
               end
            end
         end
         AH: state_n = AL;
         AL: begin
            cnt_n   = CW'(WAIT_STATES);
            state_n = r_we ? WP : RD;
         end
         RD: begin
            if (cnt == '0) begin
               if (half) rdata_n[31:16] = bus_in;
               else      rdata_n[15:0]  = bus_in;
               state_n = TURN;
            end else begin
               cnt_n = cnt - CW'(1);
            end
         end
         WP: begin
            if (cnt == '0) state_n = WH;
            else           cnt_n   = cnt - CW'(1);
         end
         TURN, WH: begin
            if (second) begin
               cur_n   = cur + AW'(1);
               half_n  = 1'b1;
               state_n = (hi_valid && (cache == cur_n[31:16])) ? AL : AH;
            end else begin
               state_n = DONE;
            end
         end
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase

      // Outputs are a function of the state being entered, so they line up with it.
      wp_data = half_n ? wdata_n[31:16] : wdata_n[15:0];
      wp_strb = half_n ? wstrb_n[3:2]   : wstrb_n[1:0];
      case (state_n)
         IDLE: req_ready_n = 1'b1;
         AH: begin
            le_hi_n    = 1'b1;
            bus_out_n  = cur_n[31:16];
            cache_n    = cur_n[31:16];
            hi_valid_n = 1'b1;
         end
         AL: begin
            le_lo_n   = 1'b1;
            bus_out_n = cur_n[15:0];
         end
         RD: begin
            bus_dir_n = 1'b1;
            oeb_n     = 1'b0;
            bus_out_n = '0;
         end
         TURN: bus_dir_n = 1'b1;
         WP: begin
            bus_out_n = wp_data;
            web_lo_n  = !wp_strb[0];
            web_hi_n  = !wp_strb[1];
         end
         WH:   ;
         DONE: ack_n = 1'b1;
         default: ;
      endcase
   end

   // State and output registers.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state     <= IDLE;
         cnt       <= '0;
         cur       <= '0;
         cache     <= '0;
         hi_valid  <= 1'b0;
         half      <= 1'b0;
         r_we      <= 1'b0;
         r_word    <= 1'b0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         rdata     <= '0;
         bus_out   <= '0;
         req_ready <= 1'b1;
         ack       <= 1'b0;
         le_lo     <= 1'b0;
         le_hi     <= 1'b0;
         bus_dir   <= 1'b0;
         bus_oe    <= 1'b1;
         OEb       <= 1'b1;
         WEb_lo    <= 1'b1;
         WEb_hi    <= 1'b1;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         cur       <= cur_n;
         cache     <= cache_n;
         hi_valid  <= hi_valid_n;
         half      <= half_n;
         r_we      <= we_n;
         r_word    <= word_n;
         r_wdata   <= wdata_n;
         r_wstrb   <= wstrb_n;
         rdata     <= rdata_n;
         bus_out   <= bus_out_n;
         req_ready <= req_ready_n;
         ack       <= ack_n;
         le_lo     <= le_lo_n;
         le_hi     <= le_hi_n;
         bus_dir   <= bus_dir_n;
         bus_oe    <= !bus_dir_n;
         OEb       <= oeb_n;
         WEb_lo    <= web_lo_n;
         WEb_hi    <= web_hi_n;
      end
   end

endmodule

// File: tb/tb_ext_bus_ctrl.sv
// Bench for ext_bus_ctrl: external latch/memory device model plus a
// transaction-level reference (memory contents, rdata, cycle counts).
module tb_ext_bus_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Instance with no wait states
   logic        rst = 1'b1, req_valid = 1'b0, req_we = 1'b0, req_word = 1'b0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic [3:0]  req_wstrb = '0;
   logic [15:0] bus_in = '0;
   logic        req_ready, ack, bus_oe, le_lo, le_hi, bus_dir, oeb, web_lo, web_hi;
   logic [31:0] rdata;
   logic [15:0] bus_out;

   ext_bus_ctrl #(.WAIT_STATES(0)) u_dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_word(req_word), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_wstrb(req_wstrb), .ack(ack), .rdata(rdata), .bus_out(bus_out), .bus_in(bus_in),
      .bus_oe(bus_oe), .le_lo(le_lo), .le_hi(le_hi), .bus_dir(bus_dir), .OEb(oeb),
      .WEb_lo(web_lo), .WEb_hi(web_hi));

   // Instance with two wait states (reads only)
   logic        rst2 = 1'b1, valid2 = 1'b0;
   logic [31:0] addr2 = '0;
   logic [15:0] bus_in2 = '0;
   logic        ready2, ack2, bus_oe2, le_lo2, le_hi2, bus_dir2, oeb2, web_lo2, web_hi2;
   logic [31:0] rdata2;
   logic [15:0] bus_out2;

   ext_bus_ctrl #(.WAIT_STATES(2)) u_dut_ws (
      .wb_clk_i(clk), .wb_rst_i(rst2), .req_valid(valid2), .req_ready(ready2),
      .req_we(1'b0), .req_word(1'b1), .req_addr(addr2), .req_wdata(32'h0),
      .req_wstrb(4'h0), .ack(ack2), .rdata(rdata2), .bus_out(bus_out2), .bus_in(bus_in2),
      .bus_oe(bus_oe2), .le_lo(le_lo2), .le_hi(le_hi2), .bus_dir(bus_dir2), .OEb(oeb2),
      .WEb_lo(web_lo2), .WEb_hi(web_hi2));

   // Device side: address latches, memory, and event logs
   logic [15:0] dev_mem [logic [31:0]];
   logic [15:0] ref_mem [logic [31:0]];
   logic [15:0] lat_hi = '0, lat_lo = '0;
   logic        web_lo_p = 1'b1, web_hi_p = 1'b1;
   logic [15:0] hi_q[$];
   logic [31:0] addr_q[$];
   int          wlo_cyc = 0, whi_cyc = 0;

   function automatic logic [15:0] init_val(input logic [31:0] a);
      return a[15:0] ^ {a[7:0], a[15:8]} ^ a[31:16] ^ 16'h5A3C;
   endfunction

   function automatic logic [15:0] dev_rd(input logic [31:0] a);
      return dev_mem.exists(a) ? dev_mem[a] : init_val(a);
   endfunction

   function automatic logic [15:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
   endfunction

   always @(negedge clk) begin
      logic [15:0] tmp;
      if (le_hi) begin lat_hi = bus_out; hi_q.push_back(bus_out); end
      if (le_lo) begin lat_lo = bus_out; addr_q.push_back({lat_hi, bus_out}); end
      if (!web_lo) wlo_cyc++;
      if (!web_hi) whi_cyc++;
      if (!web_lo_p && web_lo) begin
         tmp = dev_rd({lat_hi, lat_lo}); tmp[7:0] = bus_out[7:0]; dev_mem[{lat_hi, lat_lo}] = tmp;
      end
      if (!web_hi_p && web_hi) begin
         tmp = dev_rd({lat_hi, lat_lo}); tmp[15:8] = bus_out[15:8]; dev_mem[{lat_hi, lat_lo}] = tmp;
      end
      web_lo_p = web_lo;
      web_hi_p = web_hi;
      bus_in = oeb ? 16'h0 : dev_rd({lat_hi, lat_lo});
   end

   // Second instance: constant read data, OEb-low run lengths, le_hi and ack counts
   int ws_run = 0, hi2_cnt = 0, ack2_cnt = 0;
   int ws_runs[$];
   always @(negedge clk) begin
      if (!oeb2) ws_run++;
      else if (ws_run != 0) begin ws_runs.push_back(ws_run); ws_run = 0; end
      if (le_hi2) hi2_cnt++;
      if (ack2) ack2_cnt++;
      bus_in2 = oeb2 ? 16'h0 : 16'h1234;
   end

   // One request on the first instance; called and returns at a falling edge.
   task automatic do_txn(input logic we, input logic word, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] st,
                         output int cyc, output logic [31:0] rd, output logic rdy_issue);
      logic rdy;
      int   guard;
      req_we = we; req_word = word; req_addr = addr; req_wdata = wd; req_wstrb = st;
      req_valid = 1'b1;
      rdy_issue = req_ready;
      guard = 0;
      rdy = req_ready;
      @(posedge clk);
      while (!rdy && guard < 50) begin
         @(negedge clk);
         rdy = req_ready;
         @(posedge clk);
         guard++;
      end
      @(negedge clk);
      req_valid = 1'b0;
      cyc = 1;
      while (!ack && cyc < 200) begin @(negedge clk); cyc++; end
      if (!rdy || !ack) begin
         n_vec++; n_err++;
         $display("FAIL txn_timeout: addr=%h accepted=%0b ack=%0b after %0d cycles", addr, rdy, ack, cyc);
      end
      rd = rdata;
   endtask

   task automatic do_txn2(input logic [31:0] addr, output int cyc);
      addr2 = addr; valid2 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      valid2 = 1'b0;
      cyc = 1;
      while (!ack2 && cyc < 200) begin @(negedge clk); cyc++; end
      if (!ack2) begin
         n_vec++; n_err++;
         $display("FAIL txn2_timeout: no ack after %0d cycles", cyc);
      end
   endtask

   task automatic clear_logs();
      hi_q.delete(); addr_q.delete(); wlo_cyc = 0; whi_cyc = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1; rst2 = 1'b1; req_valid = 1'b0; valid2 = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0; rst2 = 1'b0;
      n_vec++;
      if ({req_ready, ack, le_lo, le_hi, bus_dir, bus_oe, oeb, web_lo, web_hi} !== 9'b100001111) begin
         n_err++;
         $display("FAIL reset_ctrl: got %b expected %b",
                  {req_ready, ack, le_lo, le_hi, bus_dir, bus_oe, oeb, web_lo, web_hi}, 9'b100001111);
      end
      n_vec++;
      if (rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
      n_vec++;
      if (bus_out !== 16'h0) begin n_err++; $display("FAIL reset_bus_out: got %h expected 0", bus_out); end
      n_vec++;
      if ({ready2, oeb2, bus_oe2} !== 3'b111) begin
         n_err++; $display("FAIL reset_ws: got %b expected 111", {ready2, oeb2, bus_oe2});
      end
   endtask

   task automatic test_word_read();
      int cyc; logic [31:0] rd; logic r;
      dev_mem[32'h8] = 16'h0013; dev_mem[32'h9] = 16'hABCD;
      clear_logs();
      do_txn(1'b0, 1'b1, 32'h10, 32'h0, 4'h0, cyc, rd, r);
      n_vec++;
      if (cyc != 8) begin n_err++; $display("FAIL wr1_latency: got %0d expected 8", cyc); end
      n_vec++;
      if (rd !== 32'hABCD0013) begin n_err++; $display("FAIL wr1_rdata: got %h expected abcd0013", rd); end
      n_vec++;
      if (addr_q.size() != 2 || addr_q[0] !== 32'h8 || addr_q[1] !== 32'h9) begin
         n_err++; $display("FAIL wr1_addrs: got %p expected 8,9", addr_q);
      end
      n_vec++;
      if (hi_q.size() != 1) begin n_err++; $display("FAIL wr1_le_hi: got %0d pulses expected 1", hi_q.size()); end
   endtask

   task automatic test_back_to_back();
      int cyc; logic [31:0] rd; logic r;
      clear_logs();
      do_txn(1'b0, 1'b1, 32'h20, 32'h0, 4'h0, cyc, rd, r);
      n_vec++;
      if (r !== 1'b0) begin n_err++; $display("FAIL b2b_ready_in_done: got %b expected 0", r); end
      n_vec++;
      if (cyc != 7) begin n_err++; $display("FAIL b2b_latency: got %0d expected 7", cyc); end
      n_vec++;
      if (hi_q.size() != 0) begin n_err++; $display("FAIL b2b_le_hi: got %0d pulses expected 0", hi_q.size()); end
      n_vec++;
      if (rd !== {init_val(32'h11), init_val(32'h10)}) begin
         n_err++; $display("FAIL b2b_rdata: got %h expected %h", rd, {init_val(32'h11), init_val(32'h10)});
      end
   endtask

   task automatic test_write_lo();
      int cyc; logic [31:0] rd; logic r;
      dev_mem[32'h00200006] = 16'hFFFF;
      clear_logs();
      do_txn(1'b1, 1'b0, 32'h0040000C, 32'h00000041, 4'b0011, cyc, rd, r);
      n_vec++;
      if (wlo_cyc != 1 || whi_cyc != 1) begin
         n_err++; $display("FAIL wlo_strobes: got lo=%0d hi=%0d expected 1 1", wlo_cyc, whi_cyc);
      end
      n_vec++;
      if (addr_q.size() != 1 || addr_q[0] !== 32'h00200006) begin
         n_err++; $display("FAIL wlo_addr: got %p expected 00200006", addr_q);
      end
      n_vec++;
      if (dev_rd(32'h00200006) !== 16'h0041) begin
         n_err++; $display("FAIL wlo_mem: got %h expected 0041", dev_rd(32'h00200006));
      end
      n_vec++;
      if (cyc != 5) begin n_err++; $display("FAIL wlo_latency: got %0d expected 5", cyc); end
   endtask

   task automatic test_write_hi_half();
      int cyc; logic [31:0] rd; logic r;
      dev_mem[32'h1] = 16'hAB00; dev_mem[32'h0] = 16'h7777;
      clear_logs();
      do_txn(1'b1, 1'b0, 32'h0, 32'h00550000, 4'b0100, cyc, rd, r);
      n_vec++;
      if (wlo_cyc != 1 || whi_cyc != 0) begin
         n_err++; $display("FAIL whi_strobes: got lo=%0d hi=%0d expected 1 0", wlo_cyc, whi_cyc);
      end
      n_vec++;
      if (addr_q.size() != 1 || addr_q[0] !== 32'h1) begin
         n_err++; $display("FAIL whi_addr: got %p expected 1", addr_q);
      end
      n_vec++;
      if (dev_rd(32'h1) !== 16'hAB55 || dev_rd(32'h0) !== 16'h7777) begin
         n_err++; $display("FAIL whi_mem: got %h/%h expected ab55/7777", dev_rd(32'h1), dev_rd(32'h0));
      end
      n_vec++;
      if (cyc != 5) begin n_err++; $display("FAIL whi_latency: got %0d expected 5", cyc); end
   endtask

   task automatic test_window_wrap();
      int cyc; logic [31:0] rd; logic r;
      dev_mem[32'hFFFF] = 16'h1111; dev_mem[32'h10000] = 16'h2222;
      clear_logs();
      do_txn(1'b0, 1'b1, 32'h0001FFFE, 32'h0, 4'h0, cyc, rd, r);
      n_vec++;
      if (hi_q.size() != 1 || hi_q[0] !== 16'h0001) begin
         n_err++; $display("FAIL wrap_le_hi: got %p expected 0001", hi_q);
      end
      n_vec++;
      if (addr_q.size() != 2 || addr_q[0] !== 32'hFFFF || addr_q[1] !== 32'h10000) begin
         n_err++; $display("FAIL wrap_addrs: got %p expected ffff,10000", addr_q);
      end
      n_vec++;
      if (rd !== 32'h22221111) begin n_err++; $display("FAIL wrap_rdata: got %h expected 22221111", rd); end
      n_vec++;
      if (cyc != 8) begin n_err++; $display("FAIL wrap_latency: got %0d expected 8", cyc); end
   endtask

   task automatic test_halfword_read();
      int cyc; logic [31:0] rd; logic r;
      clear_logs();
      do_txn(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, cyc, rd, r);
      n_vec++;
      if (rd !== 32'h00000013) begin n_err++; $display("FAIL hrd_rdata: got %h expected 00000013", rd); end
      n_vec++;
      if (cyc != 5) begin n_err++; $display("FAIL hrd_latency: got %0d expected 5", cyc); end
   endtask

   task automatic test_random();
      int cyc, cyc_exp;
      logic [31:0] rd, rd_exp, h, addr, wd;
      logic [3:0]  st;
      logic        we, word, r, rv;
      logic [15:0] rh, hi16, lo16, tmp;
      logic [31:0] ph[$];
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      dev_mem.delete(); ref_mem.delete();
      rv = 1'b0; rh = '0;
      for (int i = 0; i < 60; i++) begin
         we   = 1'($urandom_range(0, 1));
         word = 1'($urandom_range(0, 1));
         hi16 = 16'($urandom_range(0, 2));
         lo16 = ($urandom_range(0, 5) == 0) ? 16'hFFFF : 16'($urandom);
         h    = {hi16, lo16};
         addr = {h[30:0], 1'($urandom_range(0, 1))};
         wd   = $urandom;
         st   = 4'($urandom);
         ph.delete();
         if (we) begin
            if (st[1:0] != 2'b00) ph.push_back(h);
            if (st[3:2] != 2'b00) ph.push_back(h + 32'd1);
         end else begin
            ph.push_back(h);
            if (word) ph.push_back(h + 32'd1);
         end
         cyc_exp = 1;
         foreach (ph[k]) begin
            if (!(rv && rh == ph[k][31:16])) begin cyc_exp++; rv = 1'b1; rh = ph[k][31:16]; end
            cyc_exp += 3;
         end
         rd_exp = {word ? ref_rd(h + 32'd1) : 16'h0, ref_rd(h)};
         if (we) begin
            for (int j = 0; j < 2; j++) begin
               tmp = ref_rd(h + 32'(j));
               if (st[2*j])   tmp[7:0]  = wd[16*j +: 8];
               if (st[2*j+1]) tmp[15:8] = wd[16*j+8 +: 8];
               if (st[2*j +: 2] != 2'b00) ref_mem[h + 32'(j)] = tmp;
            end
         end
         do_txn(we, word, addr, wd, st, cyc, rd, r);
         n_vec++;
         if (cyc != cyc_exp) begin
            n_err++; $display("FAIL rnd_latency[%0d]: addr=%h we=%b got %0d expected %0d", i, addr, we, cyc, cyc_exp);
         end
         if (!we) begin
            n_vec++;
            if (rd !== rd_exp) begin
               n_err++; $display("FAIL rnd_rdata[%0d]: addr=%h got %h expected %h", i, addr, rd, rd_exp);
            end
         end else begin
            n_vec++;
            if (dev_rd(h) !== ref_rd(h) || dev_rd(h + 32'd1) !== ref_rd(h + 32'd1)) begin
               n_err++;
               $display("FAIL rnd_mem[%0d]: h=%h got %h/%h expected %h/%h", i, h,
                        dev_rd(h), dev_rd(h + 32'd1), ref_rd(h), ref_rd(h + 32'd1));
            end
         end
      end
   endtask

   task automatic test_wait_states();
      int cyc, guard;
      ws_runs.delete();
      do_txn2(32'h100, cyc);
      n_vec++;
      if (ws_runs.size() != 2 || ws_runs[0] != 3 || ws_runs[1] != 3) begin
         n_err++; $display("FAIL ws_oeb_width: got %p expected 3,3", ws_runs);
      end
      n_vec++;
      if (cyc != 12) begin n_err++; $display("FAIL ws_latency: got %0d expected 12", cyc); end
      n_vec++;
      if (rdata2 !== 32'h12341234) begin n_err++; $display("FAIL ws_rdata: got %h expected 12341234", rdata2); end
      // Abort a read in its data phase
      @(negedge clk);
      ack2_cnt = 0;
      addr2 = 32'h100; valid2 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      valid2 = 1'b0;
      guard = 0;
      while (oeb2 && guard < 20) begin @(negedge clk); guard++; end
      rst2 = 1'b1;
      @(negedge clk);
      rst2 = 1'b0;
      n_vec++;
      if ({oeb2, bus_dir2, bus_oe2, ack2, ready2} !== 5'b10101) begin
         n_err++; $display("FAIL ws_abort_state: got %b expected 10101", {oeb2, bus_dir2, bus_oe2, ack2, ready2});
      end
      repeat (3) @(negedge clk);
      n_vec++;
      if (ack2_cnt != 0) begin n_err++; $display("FAIL ws_abort_ack: got %0d acks expected 0", ack2_cnt); end
      hi2_cnt = 0;
      do_txn2(32'h100, cyc);
      n_vec++;
      if (hi2_cnt != 1) begin n_err++; $display("FAIL ws_cache_inval: got %0d le_hi expected 1", hi2_cnt); end
      n_vec++;
      if (cyc != 12) begin n_err++; $display("FAIL ws_relatency: got %0d expected 12", cyc); end
   endtask

   initial begin
      test_reset();
      test_word_read();
      test_back_to_back();
      test_write_lo();
      test_write_hi_half();
      test_window_wrap();
      test_halfword_read();
      test_random();
      test_wait_states();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule

// File: doc/ext_bus_ctrl.md
Name: ext_bus_ctrl

Overview:
- Bus interface unit inside the RISC-V core wrapper. Sits between the core's 32-bit load/store/fetch port and the chip's external 16-bit multiplexed address/data bus.
- Converts one 32-bit request into address phases (le_hi, le_lo strobes for the external transparent latches) and one or two halfword data phases (OEb for reads; WEb_lo/WEb_hi for writes, committed on their rising edge).
- Caches the upper address half so that back-to-back accesses in the same 64Ki-halfword window skip the le_hi phase.

Parameters:
- WAIT_STATES, 0, extra cycles that OEb / WEb are held low per data phase (0..15).

Ports:
- wb_clk_i  in  1  clock; all logic on rising edge.
- wb_rst_i  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; a request is accepted on an edge where req_valid && req_ready.
- req_we  in  1  1 = write, 0 = read.
- req_word  in  1  reads only: 1 = 32-bit read, 0 = single halfword read. Ignored for writes.
- req_addr  in  32  byte address; halfword address haddr = {1'b0, req_addr[31:1]}.
- req_wdata  in  32  write data; [15:0] goes to halfword haddr, [31:16] to haddr+1.
- req_wstrb  in  4  byte enables; [1:0] for halfword 0, [3:2] for halfword 1.
- ack  out  1  one-cycle completion pulse.
- rdata  out  32  read data, valid while ack is high; [15:0] from haddr, [31:16] from haddr+1 (0 for a halfword read).
- bus_out  out  16  value driven onto the pads.
- bus_in  in  16  pad input.
- bus_oe  out  1  pad output enable; equals !bus_dir.
- le_lo  out  1  low address latch enable; the latch captures on its falling edge.
- le_hi  out  1  high address latch enable.
- bus_dir  out  1  1 = memory drives the bus.
- OEb  out  1  active-low output enable.
- WEb_lo  out  1  active-low write strobe, low byte.
- WEb_hi  out  1  active-low write strobe, high byte.

Behaviour:
- All outputs are registered.
- Reset values:
  - state IDLE; req_ready=1; ack=0; rdata=0; bus_out=0.
  - le_lo=le_hi=0; bus_dir=0; bus_oe=1; OEb=1; WEb_lo=WEb_hi=1.
  - hi_valid=0 (upper-address cache invalid).
- Reset mid-operation: the next edge returns everything to reset values. No ack is issued and the cache is invalidated.
- States: IDLE, AH, AL, RD, TURN, WP, WH, DONE.
- On accept:
  - Latch all request fields; cur = haddr.
  - Write with wstrb==0: go to DONE with no bus activity.
  - Write with wstrb[1:0]==0: cur = haddr+1 and halfword 0 is skipped.
- Address dispatch: if hi_valid && cache==cur[31:16], go to AL; otherwise go to AH.
- AH (1 cycle): le_hi=1, bus_out=cur[31:16]. Load cache and set hi_valid. Then AL.
- AL (1 cycle): le_lo=1, bus_out=cur[15:0]. Then RD for a read, WP for a write.
- RD (1+WAIT_STATES cycles):
  - le=0, bus_dir=1, bus_oe=0, OEb=0, bus_out=0.
  - On the last edge, capture bus_in into the active rdata half.
  - Then TURN.
- TURN (1 cycle): OEb=1, bus_dir=1 held so the memory releases the bus before it is re-driven.
- WP (1+WAIT_STATES cycles):
  - bus_out = halfword data.
  - WEb_lo = !strb[0], WEb_hi = !strb[1] of that halfword.
  - bus_dir=0.
  - Then WH.
- WH (1 cycle): WEb_lo=WEb_hi=1 (rising edge commits the write); bus_out data held for hold time.
- After TURN or WH, a second halfword is needed if any of these hold:
  - word read on halfword 0;
  - write on halfword 0 with wstrb[3:2]!=0.
  - In that case cur=cur+1, with a 32-bit wrap (0xFFFFFFFF→0). If cur[15:0] wraps to 0 the cache no longer matches, so AH is taken through normal dispatch. Otherwise go to AL.
- When no second halfword is needed, go to DONE.
- DONE (1 cycle): ack=1, rdata valid; next state IDLE.
- req_ready: high only in IDLE. A request cannot be accepted in the DONE cycle.
- Outside RD/TURN, bus_dir=0 and bus_oe=1. In IDLE, bus_out keeps its last value.

Test Plan:
- Reset, then word read at 0x00000010 (haddr 0x8) with memory [0x8]=0x0013, [0x9]=0xABCD, WAIT_STATES=0 → sequence AH, AL, RD, TURN, AL, RD, TURN, DONE; ack in the 8th cycle after accept; rdata=0xABCD0013; latched address 0x00000008 then 0x00000009.
- Immediately issue a second word read at 0x00000020 → no le_hi pulse; ack 7 cycles after accept.
- Word write of 0x00000041 to byte address 0x0040000C, wstrb=0011 → single data phase; WEb_lo and WEb_hi both low for 1 cycle at latched address 0x00200006; memory byte=0x41; no second halfword; ack.
- Write with wstrb=0100 to 0x00000000, wdata=0x00550000 → only halfword 0x1 is written; WEb_lo low, WEb_hi high; low byte=0x55; high byte unchanged.
- Word read at byte address 0x0001FFFE (haddr 0xFFFF) → second halfword at 0x10000; second AH pulse with bus_out=0x0001, then AL with 0x0000.
- WAIT_STATES=2: OEb low exactly 3 cycles per phase. Assert wb_rst_i during RD → next edge OEb=1, bus_dir=0, no ack; next request re-issues AH.
